gpio_bank_regs: RTL and testbench

Parametrised successor to the fixed two-connector GPIO decoder: a register bank for NumGPIO connectors of GPIOWidth pins each. It holds the per-pin output data, DDR, open-drain and port-select mux registers, and synchronises pin inputs. New over the previous generation: arbitrary connector count, a software-GPIO mux code, fixed-latency read handshake, and optional edge capture with an interrupt. It sits between the CPU bus slave and the top-level tristate buffers; the hm2/hm3 output bus feeds the mux.

---
 rtl/gpio_bank_pkg.sv | 21 ++
 rtl/gpio_pin_ctrl.sv | 90 +++++++++
 rtl/gpio_bank_regs.sv | 206 ++++++++++++++++++++
 tb/tb_gpio_bank_regs.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_bank_pkg.sv
// Shared address map, mux code and sizing helper for the GPIO register bank.
// Optional edge-capture/interrupt logic is built when GPIO_EDGE_IRQ_EN is defined.
package gpio_bank_pkg;

    localparam int unsigned IO_BASE   = 32'h1000;
    localparam int unsigned DDR_BASE  = 32'h1100;
    localparam int unsigned MUX_BASE  = 32'h1120;
    localparam int unsigned EDGE_BASE = 32'h1200;
    localparam int unsigned OD_BASE   = 32'h1300;
    localparam int unsigned RISE_BASE = 32'h1400;
    localparam int unsigned FALL_BASE = 32'h1500;

    // Port-select code that routes the pin to its software io_reg bit
    localparam logic [7:0] PORTSEL_SW = 8'hFF;

    // Integer ceiling division for register-count sizing
    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/gpio_pin_ctrl.sv
// Per-pin control: drive-source mux, open-drain/DDR output stage, input synchroniser.
// Edge detection and sticky status are included when GPIO_EDGE_IRQ_EN is defined.
module gpio_pin_ctrl
    import gpio_bank_pkg::*;
#(
    parameter int unsigned NumPins      = 72,
    parameter int unsigned PortNumWidth = 8
) (
    input  logic                    clk,
    input  logic                    reset_in,
    input  logic [PortNumWidth-1:0] portsel,
    input  logic                    io_bit,
    input  logic                    ddr_bit,
    input  logic                    od_bit,
    input  logic [NumPins-1:0]      hm_out,
    input  logic                    pin_in,
    output logic                    pin_out,
    output logic                    pin_oe,
    output logic                    sync_out
`ifdef GPIO_EDGE_IRQ_EN
    ,
    input  logic                    rise_en,
    input  logic                    fall_en,
    input  logic                    status_clr,
    output logic                    status
`endif
);

    logic src_c;
    logic sync1_q;
    logic sync2_q;

    // Drive source: software bit, an hm core output, or 0 for out-of-range codes
    always_comb begin
        src_c = 1'b0;
        if (portsel == PortNumWidth'(PORTSEL_SW)) begin
            src_c = io_bit;
        end else begin
            for (int unsigned j = 0; j < NumPins; j++) begin
                if (portsel == PortNumWidth'(j)) src_c = hm_out[j];
            end
        end
    end

    // Output stage: open-drain pulls low by enabling the driver when source is 0
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            pin_out <= 1'b0;
            pin_oe  <= 1'b0;
        end else if (od_bit) begin
            pin_out <= 1'b0;
            pin_oe  <= ~src_c;
        end else begin
            pin_out <= src_c;
            pin_oe  <= ddr_bit;
        end
    end

    // Two-flop input synchroniser
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pin_in;
            sync2_q <= sync1_q;
        end
    end

    assign sync_out = sync2_q;

`ifdef GPIO_EDGE_IRQ_EN
    logic sync3_q;
    logic set_c;

    assign set_c = ((sync2_q & ~sync3_q) & rise_en) | ((~sync2_q & sync3_q) & fall_en);

    // Sticky edge status; a new edge beats a simultaneous clear
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            sync3_q <= 1'b0;
            status  <= 1'b0;
        end else begin
            sync3_q <= sync2_q;
            status  <= (status & ~status_clr) | set_c;
        end
    end
`endif

endmodule

// File: rtl/gpio_bank_regs.sv
// GPIO register bank for NumGPIO connectors: io/DDR/OD/portsel registers,
// synchronised inputs, fixed two-cycle read handshake with hm2 fallthrough.
// Define GPIO_EDGE_IRQ_EN to add edge status, rise/fall enables and irq.
module gpio_bank_regs
    import gpio_bank_pkg::*;
#(
    parameter int unsigned AddrWidth    = 16,
    parameter int unsigned BusWidth     = 32,
    parameter int unsigned NumGPIO      = 2,
    parameter int unsigned GPIOWidth    = 36,
    parameter int unsigned IoRegWidth   = 24,
    parameter int unsigned PortNumWidth = 8
) (
    input  logic                             clk,
    input  logic                             reset_in,
    input  logic [AddrWidth-1:0]             address,
    input  logic                             read,
    input  logic                             write,
    input  logic [BusWidth-1:0]              writedata,
    output logic [BusWidth-1:0]              readdata,
    output logic                             readvalid,
    input  logic [BusWidth-1:0]              fallthrough_data,
    input  logic [NumGPIO*GPIOWidth-1:0]     hm_out,
    input  logic [NumGPIO*GPIOWidth-1:0]     gpio_in,
    output logic [NumGPIO*GPIOWidth-1:0]     gpio_out,
    output logic [NumGPIO*GPIOWidth-1:0]     gpio_oe,
    output logic                             irq
);

    localparam int unsigned NumPins      = NumGPIO * GPIOWidth;
    localparam int unsigned NumIOAddrReg = ceil_div(NumPins, IoRegWidth);
    localparam int unsigned NumMuxReg    = ceil_div(NumPins, 4);
    localparam int unsigned WaW          = AddrWidth - 2;

    logic [WaW-1:0]          word_addr;
    logic                    unused_addr;
    logic [NumPins-1:0]      io_q;
    logic [NumPins-1:0]      ddr_q;
    logic [NumPins-1:0]      od_q;
    logic [PortNumWidth-1:0] portsel_q [NumPins];
    logic [NumPins-1:0]      sync_q;
    logic [WaW-1:0]          idx_io, idx_ddr, idx_mux, idx_od;
    logic                    io_hit_c, ddr_hit_c, mux_hit_c, od_hit_c;
    logic                    rd_hit_c;
    logic [BusWidth-1:0]     rd_word_c;
    logic                    rd_pend_q;
    logic                    rd_hit_q;
    logic [BusWidth-1:0]     rd_word_q;

    // Word index relative to a region base; wraps high when below the base
    function automatic logic [WaW-1:0] region_idx(input logic [WaW-1:0] wa, input int unsigned base);
        return wa - WaW'(base >> 2);
    endfunction

    // Replace the pin bits covered by data word idx
    function automatic logic [NumPins-1:0] merge_word(input logic [NumPins-1:0] cur,
                                                      input logic [WaW-1:0] idx,
                                                      input logic [BusWidth-1:0] wd);
        merge_word = cur;
        for (int unsigned i = 0; i < NumPins; i++) begin
            if (idx == WaW'(i / IoRegWidth)) merge_word[i] = wd[i % IoRegWidth];
        end
    endfunction

    // Extract data word idx from a pin vector; bits beyond NumPins read 0
    function automatic logic [BusWidth-1:0] pack_word(input logic [NumPins-1:0] v,
                                                      input logic [WaW-1:0] idx);
        pack_word = '0;
        for (int unsigned i = 0; i < NumPins; i++) begin
            if (idx == WaW'(i / IoRegWidth)) pack_word[i % IoRegWidth] = v[i];
        end
    endfunction

    assign word_addr   = address[AddrWidth-1:2];
    assign unused_addr = ^address[1:0];

    assign idx_io   = region_idx(word_addr, IO_BASE);
    assign idx_ddr  = region_idx(word_addr, DDR_BASE);
    assign idx_mux  = region_idx(word_addr, MUX_BASE);
    assign idx_od   = region_idx(word_addr, OD_BASE);
    assign io_hit_c  = idx_io  < WaW'(NumIOAddrReg);
    assign ddr_hit_c = idx_ddr < WaW'(NumIOAddrReg);
    assign mux_hit_c = idx_mux < WaW'(NumMuxReg);
    assign od_hit_c  = idx_od  < WaW'(NumIOAddrReg);

    // Control register writes
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            io_q  <= '0;
            ddr_q <= '0;
            od_q  <= '0;
            for (int unsigned i = 0; i < NumPins; i++) portsel_q[i] <= PortNumWidth'(i);
        end else if (write) begin
            if (io_hit_c)  io_q  <= merge_word(io_q, idx_io, writedata);
            if (ddr_hit_c) ddr_q <= merge_word(ddr_q, idx_ddr, writedata);
            if (od_hit_c)  od_q  <= merge_word(od_q, idx_od, writedata);
            for (int unsigned i = 0; i < NumPins; i++) begin
                if (mux_hit_c && idx_mux == WaW'(i / 4))
                    portsel_q[i] <= writedata[(i % 4) * 8 +: PortNumWidth];
            end
        end
    end

`ifdef GPIO_EDGE_IRQ_EN
    logic [WaW-1:0]     idx_edge, idx_rise, idx_fall;
    logic               edge_hit_c, rise_hit_c, fall_hit_c;
    logic [NumPins-1:0] rise_en_q, fall_en_q, status_q, status_clr_c;

    assign idx_edge   = region_idx(word_addr, EDGE_BASE);
    assign idx_rise   = region_idx(word_addr, RISE_BASE);
    assign idx_fall   = region_idx(word_addr, FALL_BASE);
    assign edge_hit_c = idx_edge < WaW'(NumIOAddrReg);
    assign rise_hit_c = idx_rise < WaW'(NumIOAddrReg);
    assign fall_hit_c = idx_fall < WaW'(NumIOAddrReg);
    assign status_clr_c = (write && edge_hit_c) ? merge_word('0, idx_edge, writedata) : '0;

    // Edge enable registers and interrupt output
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            rise_en_q <= '0;
            fall_en_q <= '0;
            irq       <= 1'b0;
        end else begin
            if (write && rise_hit_c) rise_en_q <= merge_word(rise_en_q, idx_rise, writedata);
            if (write && fall_hit_c) fall_en_q <= merge_word(fall_en_q, idx_fall, writedata);
            irq <= |status_q;
        end
    end
`else
    assign irq = 1'b0;
`endif

    // Read decode, evaluated on pre-write register state
    always_comb begin
        rd_hit_c  = 1'b1;
        rd_word_c = '0;
        if (io_hit_c) begin
            rd_word_c = pack_word(sync_q, idx_io);
        end else if (ddr_hit_c) begin
            rd_word_c = pack_word(ddr_q, idx_ddr);
        end else if (mux_hit_c) begin
            for (int unsigned i = 0; i < NumPins; i++) begin
                if (idx_mux == WaW'(i / 4)) rd_word_c[(i % 4) * 8 +: PortNumWidth] = portsel_q[i];
            end
        end else if (od_hit_c) begin
            rd_word_c = pack_word(od_q, idx_od);
`ifdef GPIO_EDGE_IRQ_EN
        end else if (edge_hit_c) begin
            rd_word_c = pack_word(status_q, idx_edge);
        end else if (rise_hit_c) begin
            rd_word_c = pack_word(rise_en_q, idx_rise);
        end else if (fall_hit_c) begin
            rd_word_c = pack_word(fall_en_q, idx_fall);
`endif
        end else begin
            rd_hit_c = 1'b0;
        end
    end

    // Two-stage read pipeline; fallthrough data is taken in the second stage
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            rd_pend_q <= 1'b0;
            rd_hit_q  <= 1'b0;
            rd_word_q <= '0;
            readdata  <= '0;
            readvalid <= 1'b0;
        end else begin
            rd_pend_q <= read;
            if (read) begin
                rd_hit_q  <= rd_hit_c;
                rd_word_q <= rd_word_c;
            end
            readvalid <= rd_pend_q;
            if (rd_pend_q) readdata <= rd_hit_q ? rd_word_q : fallthrough_data;
        end
    end

    // One control slice per pin
    for (genvar i = 0; i < NumPins; i++) begin : g_pin
        gpio_pin_ctrl #(
            .NumPins      (NumPins),
            .PortNumWidth (PortNumWidth)
        ) u_pin (
            .clk        (clk),
            .reset_in   (reset_in),
            .portsel    (portsel_q[i]),
            .io_bit     (io_q[i]),
            .ddr_bit    (ddr_q[i]),
            .od_bit     (od_q[i]),
            .hm_out     (hm_out),
            .pin_in     (gpio_in[i]),
            .pin_out    (gpio_out[i]),
            .pin_oe     (gpio_oe[i]),
            .sync_out   (sync_q[i])
`ifdef GPIO_EDGE_IRQ_EN
            ,
            .rise_en    (rise_en_q[i]),
            .fall_en    (fall_en_q[i]),
            .status_clr (status_clr_c[i]),
            .status     (status_q[i])
`endif
        );
    end

endmodule

// File: tb/tb_gpio_bank_regs.sv
// Directed bench for gpio_bank_regs (default 2 x 36 pins, 24-bit data words).
module tb_gpio_bank_regs;

    localparam int NP = 72;

    logic            clk = 1'b0;
    logic            reset_in = 1'b1;
    logic [15:0]     address = '0;
    logic            read = 1'b0;
    logic            write = 1'b0;
    logic [31:0]     writedata = '0;
    logic [31:0]     readdata;
    logic            readvalid;
    logic [31:0]     fallthrough_data = 32'hCAFE_F00D;
    logic [NP-1:0]   hm_out = '0;
    logic [NP-1:0]   gpio_in = '0;
    logic [NP-1:0]   gpio_out;
    logic [NP-1:0]   gpio_oe;
    logic            irq;

    int checks = 0;
    int errors = 0;

    gpio_bank_regs dut (
        .clk              (clk),
        .reset_in         (reset_in),
        .address          (address),
        .read             (read),
        .write            (write),
        .writedata        (writedata),
        .readdata         (readdata),
        .readvalid        (readvalid),
        .fallthrough_data (fallthrough_data),
        .hm_out           (hm_out),
        .gpio_in          (gpio_in),
        .gpio_out         (gpio_out),
        .gpio_oe          (gpio_oe),
        .irq              (irq)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    // Read with fixed latency; pulse_ok reports a clean one-cycle readvalid at N+2
    task automatic bus_read(input logic [15:0] a, output logic [31:0] d, output logic pulse_ok);
        logic v0, v1, v2;
        @(negedge clk);
        address = a; read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        v0 = readvalid;
        @(negedge clk);
        v1 = readvalid; d = readdata;
        @(negedge clk);
        v2 = readvalid;
        pulse_ok = !v0 && v1 && !v2;
    endtask

    task automatic test_reset;
        logic [31:0] d; logic ok;
        #1;
        checks++; if ({readdata, readvalid, irq} !== 34'd0) begin errors++;
            $display("FAIL reset_bus: got rd=%h rv=%b irq=%b expected 0", readdata, readvalid, irq); end
        checks++; if ({gpio_out, gpio_oe} !== '0) begin errors++;
            $display("FAIL reset_pins: got out=%h oe=%h expected 0", gpio_out, gpio_oe); end
        repeat (2) @(negedge clk);
        reset_in = 1'b0;
        bus_read(16'h1120, d, ok);
        checks++; if (d !== 32'h0302_0100) begin errors++;
            $display("FAIL portsel_default: got %h expected 03020100", d); end
        checks++; if (ok !== 1'b1) begin errors++;
            $display("FAIL readvalid_pulse: got %b expected 1", ok); end
        bus_read(16'h1000, d, ok);
        checks++; if (d !== 32'h0) begin errors++;
            $display("FAIL input_zero: got %h expected 0", d); end
    endtask

    task automatic test_sw_gpio;
        logic [31:0] d; logic ok;
        bus_write(16'h1120, 32'h0000_00FF);
        bus_write(16'h1000, 32'h1);
        bus_write(16'h1100, 32'h1);
        @(negedge clk);
        checks++; if ({gpio_out[0], gpio_oe[0]} !== 2'b11) begin errors++;
            $display("FAIL sw_drive: got out=%b oe=%b expected 1 1", gpio_out[0], gpio_oe[0]); end
        bus_write(16'h1300, 32'h1);
        @(negedge clk);
        checks++; if ({gpio_out[0], gpio_oe[0]} !== 2'b00) begin errors++;
            $display("FAIL od_high: got out=%b oe=%b expected 0 0", gpio_out[0], gpio_oe[0]); end
        bus_write(16'h1000, 32'h0);
        @(negedge clk);
        checks++; if ({gpio_out[0], gpio_oe[0]} !== 2'b01) begin errors++;
            $display("FAIL od_low: got out=%b oe=%b expected 0 1", gpio_out[0], gpio_oe[0]); end
        bus_read(16'h1120, d, ok);
        checks++; if (d !== 32'h0000_00FF) begin errors++;
            $display("FAIL portsel_readback: got %h expected 000000ff", d); end
    endtask

    task automatic test_hm_mux;
        hm_out[70] = 1'b1;
        bus_write(16'h1124, 32'h0706_4604);
        bus_write(16'h1100, 32'h21);
        @(negedge clk);
        checks++; if ({gpio_out[5], gpio_oe[5]} !== 2'b11) begin errors++;
            $display("FAIL hm_route: got out=%b oe=%b expected 1 1", gpio_out[5], gpio_oe[5]); end
        hm_out[70] = 1'b0;
        @(negedge clk);
        checks++; if (gpio_out[5] !== 1'b0) begin errors++;
            $display("FAIL hm_follow: got %b expected 0", gpio_out[5]); end
        hm_out[70] = 1'b1;
        bus_write(16'h1124, 32'h0706_6404);
        @(negedge clk);
        checks++; if (gpio_out[5] !== 1'b0) begin errors++;
            $display("FAIL portsel_oob: got %b expected 0", gpio_out[5]); end
    endtask

    task automatic test_input_and_bounds;
        logic [31:0] d; logic ok;
        gpio_in[30] = 1'b1;
        gpio_in[71] = 1'b1;
        repeat (3) @(negedge clk);
        bus_read(16'h1004, d, ok);
        checks++; if (d !== 32'h0000_0040) begin errors++;
            $display("FAIL input_pin30: got %h expected 00000040", d); end
        bus_read(16'h1008, d, ok);
        checks++; if (d !== 32'h0080_0000) begin errors++;
            $display("FAIL input_pin71: got %h expected 00800000", d); end
        bus_write(16'h1108, 32'hFFFF_FFFF);
        bus_read(16'h1108, d, ok);
        checks++; if (d !== 32'h00FF_FFFF) begin errors++;
            $display("FAIL ddr_upper_bits: got %h expected 00ffffff", d); end
        bus_write(16'h1108, 32'h0);
        bus_read(16'h1164, d, ok);
        checks++; if (d !== 32'h4746_4544) begin errors++;
            $display("FAIL portsel_last: got %h expected 47464544", d); end
        bus_read(16'h1168, d, ok);
        checks++; if (d !== 32'hCAFE_F00D) begin errors++;
            $display("FAIL portsel_past_end: got %h expected cafef00d", d); end
        gpio_in = '0;
    endtask

    task automatic test_fallthrough;
        @(negedge clk);
        address = 16'h1018; read = 1'b1; fallthrough_data = 32'hAAAA_0001;
        @(negedge clk);
        read = 1'b0; fallthrough_data = 32'h5A5A_1234;
        @(negedge clk);
        fallthrough_data = 32'hDEAD_BEEF;
        checks++; if ({readvalid, readdata} !== {1'b1, 32'h5A5A_1234}) begin errors++;
            $display("FAIL fallthrough: got rv=%b rd=%h expected 1 5a5a1234", readvalid, readdata); end
        fallthrough_data = 32'hCAFE_F00D;
    endtask

    task automatic test_back_to_back;
        logic [31:0] d; logic ok;
        @(negedge clk);
        address = 16'h1300; writedata = 32'h3; write = 1'b1; read = 1'b1;
        @(negedge clk);
        write = 1'b0; read = 1'b0;
        @(negedge clk);
        checks++; if ({readvalid, readdata} !== {1'b1, 32'h1}) begin errors++;
            $display("FAIL rw_same_cycle: got rv=%b rd=%h expected 1 00000001", readvalid, readdata); end
        bus_read(16'h1300, d, ok);
        checks++; if (d !== 32'h3) begin errors++;
            $display("FAIL rw_after: got %h expected 00000003", d); end
        bus_write(16'h1300, 32'h1);
    endtask

`ifdef GPIO_EDGE_IRQ_EN
    task automatic test_edge_irq;
        logic [31:0] d; logic ok;
        bus_write(16'h1400, 32'h8);
        @(negedge clk);
        gpio_in[3] = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++;
            $display("FAIL irq_set: got %b expected 1", irq); end
        bus_read(16'h1200, d, ok);
        checks++; if (d !== 32'h8) begin errors++;
            $display("FAIL edge_status: got %h expected 00000008", d); end
        gpio_in[3] = 1'b0;
        repeat (3) @(negedge clk);
        bus_write(16'h1200, 32'h8);
        @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++;
            $display("FAIL irq_clear: got %b expected 0", irq); end
        gpio_in[3] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        address = 16'h1200; writedata = 32'h8; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
        bus_read(16'h1200, d, ok);
        checks++; if (d !== 32'h8) begin errors++;
            $display("FAIL set_beats_clear: got %h expected 00000008", d); end
        gpio_in[3] = 1'b0;
    endtask
`else
    task automatic test_edge_irq;
        logic [31:0] d; logic ok;
        bus_read(16'h1200, d, ok);
        checks++; if (d !== 32'hCAFE_F00D) begin errors++;
            $display("FAIL edge_undecoded: got %h expected cafef00d", d); end
        checks++; if (irq !== 1'b0) begin errors++;
            $display("FAIL irq_tied: got %b expected 0", irq); end
    endtask
`endif

    task automatic test_reset_mid_read;
        logic seen;
        checks++; if (gpio_oe[0] !== 1'b1) begin errors++;
            $display("FAIL pre_reset_oe: got %b expected 1", gpio_oe[0]); end
        @(negedge clk);
        address = 16'h1000; read = 1'b1;
        @(negedge clk);
        read = 1'b0; reset_in = 1'b1;
        #1;
        checks++; if ({readdata, readvalid, irq, gpio_out, gpio_oe} !== '0) begin errors++;
            $display("FAIL async_reset: got rd=%h rv=%b irq=%b out=%h oe=%h expected 0",
                     readdata, readvalid, irq, gpio_out, gpio_oe); end
        @(negedge clk);
        reset_in = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen = seen | readvalid;
        end
        checks++; if (seen !== 1'b0) begin errors++;
            $display("FAIL suppressed_valid: got %b expected 0", seen); end
    endtask

    initial begin
        test_reset();
        test_sw_gpio();
        test_hm_mux();
        test_input_and_bounds();
        test_fallthrough();
        test_back_to_back();
        test_edge_irq();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
